// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB slave with byte-addressed on-chip SRAM and a two-cycle ERROR
// response. Define AHB_SRAM_WAIT_EN to add one wait state to every legal NONSEQ.
module ahb_sram_slave #(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRST_N,
    input  logic              HSEL_i,
    input  logic [ADDR_W-1:0] HADDR_i,
    input  logic [1:0]        HTRANS_i,
    input  logic              HWRITE_i,
    input  logic [2:0]        HSIZE_i,
    input  logic [2:0]        HBURST_i,
    input  logic [31:0]       HWDATA_i,
    input  logic              HREADY_i,
    output logic              HREADY_o,
    output logic              HRESP_o,
    output logic [31:0]       HRDATA_o
);
    localparam int AW = $clog2(MEM_BYTES);

`ifdef AHB_SRAM_WAIT_EN
    typedef enum logic [2:0] {IDLE, DATA, ERR1, ERR2, WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, ERR1, ERR2} state_t;
`endif

    state_t        state, state_nxt, legal_nxt;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic [7:0]    mem [MEM_BYTES];
    logic          accept, active, illegal;
    logic [AW-1:0] word_a;
    logic [3:0]    be;
    logic          unused_ok;

    // Burst type only matters to the master; the slave just follows HTRANS.
    assign unused_ok = ^HBURST_i;

    // ERR1 and WAIT hold HREADY low, so an address shown then is not ours to take.
    assign accept  = state == IDLE || state == DATA || state == ERR2;
    assign active  = accept && HSEL_i && HREADY_i && HTRANS_i[1];
    assign illegal = (HADDR_i >= ADDR_W'(MEM_BYTES)) || (HSIZE_i > 3'd2) ||
                     (HSIZE_i == 3'd1 && HADDR_i[0]) ||
                     (HSIZE_i == 3'd2 && HADDR_i[1:0] != 2'b00);

`ifdef AHB_SRAM_WAIT_EN
    assign legal_nxt = HTRANS_i == 2'b10 ? WAIT : DATA;
`else
    assign legal_nxt = DATA;
`endif

    assign word_a = {addr_q[AW-1:2], 2'b00};
    assign be     = size_q == 3'd0 ? 4'b0001 << addr_q[1:0] :
                    size_q == 3'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Next-state: ERR1 always runs into ERR2, WAIT into DATA, the rest decode the bus.
    always_comb begin
        state_nxt = state;
        case (state)
            ERR1:    state_nxt = ERR2;
`ifdef AHB_SRAM_WAIT_EN
            WAIT:    state_nxt = DATA;
`endif
            default: state_nxt = !active ? IDLE : illegal ? ERR1 : legal_nxt;
        endcase
    end

    // Response outputs and read data are decoded from the state alone.
    always_comb begin
        HREADY_o = 1'b1;
        HRESP_o  = 1'b0;
        HRDATA_o = '0;
`ifdef AHB_SRAM_WAIT_EN
        HREADY_o = state != ERR1 && state != WAIT;
`else
        HREADY_o = state != ERR1;
`endif
        HRESP_o  = state == ERR1 || state == ERR2;
        HRDATA_o = state == DATA ? {mem[word_a + AW'(3)], mem[word_a + AW'(2)],
                                    mem[word_a + AW'(1)], mem[word_a]} : '0;
    end

    // State register; reset abandons any data phase in flight.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) state <= IDLE;
        else         state <= state_nxt;
    end

    // Capture the fields of each legal transfer for its data phase.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else if (active && !illegal) begin
            addr_q  <= HADDR_i[AW-1:0];
            size_q  <= HSIZE_i;
            write_q <= HWRITE_i;
        end
    end

    // Commit write lanes on the edge that ends the data phase; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (state == DATA && write_q)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[word_a + AW'(k)] <= HWDATA_i[8*k +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed pipelined AHB traffic against ahb_sram_slave (works with or without AHB_SRAM_WAIT_EN).
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_WAIT_EN
    localparam int NS_WAIT = 1;
`else
    localparam int NS_WAIT = 0;
`endif
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        hsel = 1'b1, hwrite = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = T_IDLE;
    logic [2:0]  hsize = '0, hburst = '0;
    logic        hready, hresp;
    logic [31:0] hrdata;

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } item_t;

    item_t       q[$];
    logic [31:0] rd_q[$];
    logic        rs_q[$];
    int          waits, err1_cycles;
    int          n_pass = 0, n_total = 0;

    ahb_sram_slave dut (
        .HCLK(clk), .HRST_N(rst_n), .HSEL_i(hsel), .HADDR_i(haddr),
        .HTRANS_i(htrans), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst),
        .HWDATA_i(hwdata), .HREADY_i(hready), .HREADY_o(hready),
        .HRESP_o(hresp), .HRDATA_o(hrdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] a, input logic w,
                        input logic [2:0] s, input logic [31:0] d);
        q.push_back('{t, a, w, s, d});
    endtask

    // Plays q as a pipelined bus; records read data and response of each active beat
    // in the cycle its data phase completes, counts low-HREADY cycles.
    task automatic run_pipe();
        item_t pend;
        bit    pend_v = 0, hr;
        int    i = 0, guard = 0;
        waits = 0;
        err1_cycles = 0;
        rd_q.delete();
        rs_q.delete();
        pend = '0;
        while ((i < q.size() || pend_v) && guard < 300) begin
            hr = hready;
            if (!hr && hresp) err1_cycles++;
            if (hr && pend_v) begin
                rd_q.push_back(hrdata);
                rs_q.push_back(hresp);
            end
            if (i < q.size()) begin
                htrans = q[i].trans;
                haddr  = q[i].addr;
                hwrite = q[i].wr;
                hsize  = q[i].size;
            end else htrans = T_IDLE;
            hwdata = pend_v ? pend.wdata : 32'h0;
            step();
            if (hr) begin
                pend_v = i < q.size() && q[i].trans[1];
                if (i < q.size()) begin
                    pend = q[i];
                    i++;
                end
            end else waits++;
            guard++;
        end
        htrans = T_IDLE;
        q.delete();
        n_total++;
        if (guard >= 300) $display("FAIL pipe_timeout: %0d cycles used, required under 300", guard);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_total++; if (hready !== 1'b1) $display("FAIL reset_hready: got %b want 1", hready); else n_pass++;
        n_total++; if (hresp !== 1'b0) $display("FAIL reset_hresp: got %b want 0", hresp); else n_pass++;
        n_total++; if (hrdata !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", hrdata); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word_rw();
        hburst = 3'd0;
        push(T_NSEQ, 32'h10, 1, 3'd2, 32'h11223344);
        push(T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rd_q.size() != 2 || rd_q[1] !== 32'h11223344) $display("FAIL word_read: got %h want 11223344", rd_q.size() > 1 ? rd_q[1] : 32'hx); else n_pass++;
        n_total++; if (rs_q.size() != 2 || rs_q[0] !== 1'b0 || rs_q[1] !== 1'b0) $display("FAIL word_resp: got %0d entries, want two OKAY", rs_q.size()); else n_pass++;
        n_total++; if (waits != 2 * NS_WAIT) $display("FAIL word_waits: got %0d want %0d", waits, 2 * NS_WAIT); else n_pass++;
    endtask

    task automatic test_halfword();
        push(T_NSEQ, 32'h12, 1, 3'd1, 32'hBEEF0000);
        push(T_NSEQ, 32'h11, 0, 3'd0, 32'h0);
        push(T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rd_q.size() != 3 || rd_q[1] !== 32'hBEEF3344) $display("FAIL hw_byte_read_full_word: got %h want beef3344", rd_q.size() > 1 ? rd_q[1] : 32'hx); else n_pass++;
        n_total++; if (rd_q.size() != 3 || rd_q[2] !== 32'hBEEF3344) $display("FAIL hw_merge: got %h want beef3344", rd_q.size() > 2 ? rd_q[2] : 32'hx); else n_pass++;
    endtask

    task automatic test_byte_burst();
        logic [31:0] exp_w;
        hburst = 3'b111;
        for (int i = 0; i < 16; i++) begin
            push(i == 0 ? T_NSEQ : T_SEQ, 32'h20 + i, 1, 3'd0, 32'(i) << (8 * (i % 4)));
            if (i % 4 == 3 && i != 15) push(T_BUSY, 32'h21 + i, 1, 3'd0, 32'h0);
        end
        run_pipe();
        n_total++; if (waits != NS_WAIT) $display("FAIL burst_busy_waits: got %0d want %0d", waits, NS_WAIT); else n_pass++;
        hburst = 3'b011;
        for (int i = 0; i < 4; i++) push(i == 0 ? T_NSEQ : T_SEQ, 32'h20 + 4 * i, 0, 3'd2, 32'h0);
        run_pipe();
        for (int i = 0; i < 4; i++) begin
            exp_w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
            n_total++;
            if (rd_q.size() != 4 || rd_q[i] !== exp_w) $display("FAIL burst_read_%0d: got %h want %h", i, rd_q.size() > i ? rd_q[i] : 32'hx, exp_w);
            else n_pass++;
        end
        n_total++; if (waits != NS_WAIT) $display("FAIL burst_read_waits: got %0d want %0d", waits, NS_WAIT); else n_pass++;
    endtask

    task automatic test_out_of_range();
        hburst = 3'd0;
        push(T_NSEQ, 32'h200, 0, 3'd2, 32'h0);
        push(T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rs_q.size() != 2 || rs_q[0] !== 1'b1) $display("FAIL oor_resp_err2: got %0d entries, want ERROR first", rs_q.size()); else n_pass++;
        n_total++; if (err1_cycles != 1) $display("FAIL oor_err1_cycles: got %0d want 1", err1_cycles); else n_pass++;
        n_total++; if (waits != 1 + NS_WAIT) $display("FAIL oor_waits: got %0d want %0d", waits, 1 + NS_WAIT); else n_pass++;
        n_total++; if (rs_q.size() != 2 || rs_q[1] !== 1'b0 || rd_q[1] !== 32'hBEEF3344) $display("FAIL oor_followup: got %h want OKAY beef3344", rd_q.size() > 1 ? rd_q[1] : 32'hx); else n_pass++;
        push(T_NSEQ, 32'h210, 1, 3'd2, 32'h99999999);
        push(T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rs_q.size() != 2 || rs_q[0] !== 1'b1 || rd_q[1] !== 32'hBEEF3344) $display("FAIL oor_write_dropped: got %h want beef3344 after ERROR", rd_q.size() > 1 ? rd_q[1] : 32'hx); else n_pass++;
    endtask

    task automatic test_misaligned();
        push(T_NSEQ, 32'h00, 1, 3'd2, 32'h76543210);
        push(T_NSEQ, 32'h02, 1, 3'd2, 32'hDEADBEEF);
        push(T_NSEQ, 32'h00, 1, 3'd3, 32'hFFFFFFFF);
        push(T_NSEQ, 32'h01, 1, 3'd1, 32'hAAAAAAAA);
        push(T_NSEQ, 32'h00, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rs_q.size() != 5 || {rs_q[0], rs_q[1], rs_q[2], rs_q[3], rs_q[4]} !== 5'b01110) $display("FAIL mis_resps: got %0d entries, want OKAY,ERR,ERR,ERR,OKAY", rs_q.size()); else n_pass++;
        n_total++; if (err1_cycles != 3) $display("FAIL mis_err1_cycles: got %0d want 3", err1_cycles); else n_pass++;
        n_total++; if (rd_q.size() != 5 || rd_q[4] !== 32'h76543210) $display("FAIL mis_mem_unchanged: got %h want 76543210", rd_q.size() > 4 ? rd_q[4] : 32'hx); else n_pass++;
    endtask

    task automatic test_wait_seq();
        hburst = 3'b001;
        push(T_NSEQ, 32'h24, 0, 3'd2, 32'h0);
        push(T_SEQ, 32'h28, 0, 3'd2, 32'h0);
        push(T_SEQ, 32'h2C, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (waits != NS_WAIT) $display("FAIL wait_only_nonseq: got %0d want %0d", waits, NS_WAIT); else n_pass++;
        n_total++; if (rd_q.size() != 3 || rd_q[2] !== 32'h0F0E0D0C) $display("FAIL wait_seq_data: got %h want 0f0e0d0c", rd_q.size() > 2 ? rd_q[2] : 32'hx); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int guard = 0;
        hburst = 3'd0;
        htrans = T_NSEQ; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        step();
        htrans = T_IDLE;
        hwdata = 32'hCAFEF00D;
        while (!hready && guard < 10) begin
            step();
            guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (hready !== 1'b1) $display("FAIL rst_mid_hready: got %b want 1", hready); else n_pass++;
        n_total++; if (hresp !== 1'b0) $display("FAIL rst_mid_hresp: got %b want 0", hresp); else n_pass++;
        n_total++; if (hrdata !== 32'h0) $display("FAIL rst_mid_hrdata: got %h want 0", hrdata); else n_pass++;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        hwdata = 32'h0;
        step();
        push(T_NSEQ, 32'h10, 0, 3'd2, 32'h0);
        run_pipe();
        n_total++; if (rd_q.size() != 1 || rd_q[0] !== 32'hBEEF3344) $display("FAIL rst_write_dropped: got %h want beef3344", rd_q.size() > 0 ? rd_q[0] : 32'hx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_halfword();
        test_byte_burst();
        test_out_of_range();
        test_misaligned();
        test_wait_seq();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
